// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: address map constants and decode helper shared by the data-memory responder
package dmem_responder_pkg;
    localparam int         RAM_DEPTH_DEF = 240;
    localparam logic [7:0] MMIO_BASE_DEF = 8'hFC;
    localparam logic [7:0] WP_TOP_DEF    = 8'h0F;
    localparam logic [1:0] MMIO_OUT      = 2'd0;
    localparam logic [1:0] MMIO_STAT     = 2'd1;
    localparam logic [1:0] MMIO_CYC      = 2'd2;
    localparam logic [1:0] MMIO_WCNT     = 2'd3;
    typedef enum logic [1:0] {RGN_RAM, RGN_MMIO, RGN_NONE} region_e;
    function automatic region_e decode(input logic [7:0] addr, input int depth, input logic [7:0] base);
        logic [7:0] off;
        off = addr - base;
        return int'(addr) < depth ? RGN_RAM : off < 8'd4 ? RGN_MMIO : RGN_NONE;
    endfunction
endpackage

// File: rtl/dmem_mmio.sv
// dmem_mmio: output latch, io_valid pulse, cycle/write counters and sticky error flag
module dmem_mmio
    import dmem_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic       sel,
    input  logic [1:0] off,
    input  logic [7:0] d_in,
    input  logic       err_set,
    output logic [7:0] io_out,
    output logic       io_valid,
    output logic       err,
    output logic [7:0] rd_data
);
    logic [7:0] out_q, out_d, cyc_q, cyc_d, wcnt_q, wcnt_d;
    logic       valid_q, valid_d, err_q, err_d;
    always_comb begin
        valid_d = wr && sel && off == MMIO_OUT;
        out_d   = valid_d ? d_in : out_q;
        cyc_d   = cyc_q + 8'd1;
        wcnt_d  = !wr ? wcnt_q : (sel && off == MMIO_WCNT) ? 8'h00 : (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
        err_d   = err_q | err_set;
        rd_data = off == MMIO_OUT  ? out_q :
                  off == MMIO_STAT ? {6'b0, err_q, valid_q} :
                  off == MMIO_CYC  ? cyc_q : wcnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= 8'h00;
            cyc_q   <= 8'h00;
            wcnt_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            cyc_q   <= cyc_d;
            wcnt_q  <= wcnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
    assign io_out   = out_q;
    assign io_valid = valid_q;
    assign err      = err_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: RAM + MMIO slave for the minicpu data port; DMEM_WPROT_EN write-protects 0..WP_TOP
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int         RAM_DEPTH = RAM_DEPTH_DEF,
    parameter logic [7:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter logic [7:0] WP_TOP    = WP_TOP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ram_addr,
    input  logic [7:0] ram_d_in,
    output logic [7:0] ram_d_out,
    input  logic       ram_rd_,
    input  logic       ram_wr_,
    output logic [7:0] io_out,
    output logic       io_valid,
    output logic       err
);
    logic [7:0] mem [RAM_DEPTH];
    region_e    rgn;
    logic [1:0] off;
    logic       wr, prot, ram_we, err_set;
    logic [7:0] mmio_rd;
    always_comb begin
        rgn     = decode(ram_addr, RAM_DEPTH, MMIO_BASE);
        off     = 2'(ram_addr - MMIO_BASE);
        wr      = !ram_wr_;
`ifdef DMEM_WPROT_EN
        prot    = rgn == RGN_RAM && ram_addr <= WP_TOP;
`else
        prot    = 1'b0;
`endif
        ram_we  = wr && rgn == RGN_RAM && !prot;
        err_set = wr && (rgn == RGN_NONE || !ram_rd_ || prot);
        ram_d_out = (rst || ram_rd_) ? 8'h00 :
                    rgn == RGN_RAM   ? mem[ram_addr] :
                    rgn == RGN_MMIO  ? mmio_rd : 8'h00;
    end
`ifndef DMEM_WPROT_EN
    logic unused_wp;
    assign unused_wp = ^WP_TOP;
`endif
    // RAM contents are deliberately not reset; a write coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (ram_we && !rst) mem[ram_addr] <= ram_d_in;
    end
    dmem_mmio u_mmio (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .sel     (rgn == RGN_MMIO),
        .off     (off),
        .d_in    (ram_d_in),
        .err_set (err_set),
        .io_out  (io_out),
        .io_valid(io_valid),
        .err     (err),
        .rd_data (mmio_rd)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors plus a per-cycle reference model of the data-memory responder
module tb_dmem_responder;
`ifdef DMEM_WPROT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif
    logic       clk = 1'b0, rst;
    logic [7:0] ram_addr, ram_d_in, ram_d_out, io_out;
    logic       ram_rd_, ram_wr_, io_valid, err;
    int         n_chk = 0, n_fail = 0;
    bit         cmp_en = 1'b0;
    logic [7:0] m_mem [256];
    bit         m_known [256];
    logic [7:0] m_out = 8'h00, m_cyc = 8'h00, m_wcnt = 8'h00;
    bit         m_valid = 1'b0, m_err = 1'b0;

    dmem_responder dut (
        .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out),
        .ram_rd_(ram_rd_), .ram_wr_(ram_wr_), .io_out(io_out), .io_valid(io_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out = 8'h00; m_cyc = 8'h00; m_wcnt = 8'h00; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (!ram_wr_) begin
                if (!ram_rd_) m_err = 1'b1;
                if (ram_addr < 8'd240) begin
                    if (WP && ram_addr <= 8'h0F) m_err = 1'b1;
                    else begin m_mem[ram_addr] = ram_d_in; m_known[ram_addr] = 1'b1; end
                end else if (ram_addr < 8'hFC) m_err = 1'b1;
                else if (ram_addr == 8'hFC) begin m_out = ram_d_in; m_valid = 1'b1; end
                m_wcnt = (ram_addr == 8'hFF) ? 8'h00 : (m_wcnt == 8'hFF) ? 8'hFF : m_wcnt + 8'd1;
            end
            m_cyc = m_cyc + 8'd1;
        end
    end

    function automatic logic [7:0] exp_rd();
        if (rst || ram_rd_) return 8'h00;
        if (ram_addr < 8'd240) return m_mem[ram_addr];
        case (ram_addr)
            8'hFC:   return m_out;
            8'hFD:   return {6'b0, m_err, m_valid};
            8'hFE:   return m_cyc;
            8'hFF:   return m_wcnt;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_io_out", io_out, m_out);
            chk("m_io_valid", {7'b0, io_valid}, {7'b0, m_valid});
            chk("m_err", {7'b0, err}, {7'b0, m_err});
            if (rst || ram_rd_ || ram_addr >= 8'd240 || m_known[ram_addr])
                chk("m_ram_d_out", ram_d_out, exp_rd());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_t(input logic [7:0] a, input logic [7:0] d);
        ram_addr = a; ram_d_in = d; ram_rd_ = 1'b1; ram_wr_ = 1'b0;
        step();
        ram_wr_ = 1'b1;
    endtask

    task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string nm);
        ram_addr = a; ram_rd_ = 1'b0;
        #1;
        chk(nm, ram_d_out, exp);
        ram_rd_ = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ram_addr = 8'h00; ram_d_in = 8'h00; ram_rd_ = 1'b1; ram_wr_ = 1'b1;
        repeat (3) step();
        ram_addr = 8'hFC; ram_rd_ = 1'b0;
        #1;
        chk("rst_rd", ram_d_out, 8'h00);
        chk("rst_io_out", io_out, 8'h00);
        chk("rst_valid", {7'b0, io_valid}, 8'h00);
        chk("rst_err", {7'b0, err}, 8'h00);
        ram_rd_ = 1'b1;
        rst = 1'b0;
        cmp_en = 1'b1;
        repeat (260) step();
        peek(8'hFE, 8'h04, "cyc_wrap");
        wr_t(8'h10, 8'h5A);
        peek(8'h10, 8'h5A, "ram_rd");
        ram_addr = 8'h10;
        #1;
        chk("rd_idle", ram_d_out, 8'h00);
        wr_t(8'hFC, 8'h3C);
        chk("out_val", io_out, 8'h3C);
        chk("valid_hi", {7'b0, io_valid}, 8'h01);
        peek(8'hFD, 8'h01, "stat_v");
        step();
        chk("valid_lo", {7'b0, io_valid}, 8'h00);
        peek(8'hFD, 8'h00, "stat_0");
        ram_addr = 8'hFC; ram_d_in = 8'hA1; ram_wr_ = 1'b0;
        step();
        chk("b2b_valid1", {7'b0, io_valid}, 8'h01);
        ram_d_in = 8'hA2;
        step();
        ram_wr_ = 1'b1;
        chk("b2b_valid2", {7'b0, io_valid}, 8'h01);
        chk("b2b_out", io_out, 8'hA2);
        step();
        chk("b2b_valid3", {7'b0, io_valid}, 8'h00);
        wr_t(8'hFF, 8'h00);
        peek(8'hFF, 8'h00, "wcnt_clr0");
        for (int i = 0; i < 300; i++) wr_t(8'h40 + 8'(i % 64), 8'(i));
        peek(8'hFF, 8'hFF, "wcnt_sat");
        wr_t(8'hFF, 8'h12);
        peek(8'hFF, 8'h00, "wcnt_clr");
        chk("err_pre", {7'b0, err}, 8'h00);
        wr_t(8'h20, 8'h11);
        ram_addr = 8'h20; ram_d_in = 8'h22; ram_rd_ = 1'b0; ram_wr_ = 1'b0;
        #1;
        chk("rbw_old", ram_d_out, 8'h11);
        step();
        ram_wr_ = 1'b1;
        #1;
        chk("rbw_new", ram_d_out, 8'h22);
        chk("err_rw", {7'b0, err}, 8'h01);
        ram_rd_ = 1'b1;
        step();
        chk("err_sticky", {7'b0, err}, 8'h01);
        #2;
        ram_addr = 8'h10; ram_d_in = 8'h77; ram_wr_ = 1'b0; rst = 1'b1;
        #1;
        chk("async_out", io_out, 8'h00);
        chk("async_err", {7'b0, err}, 8'h00);
        step();
        ram_wr_ = 1'b1; rst = 1'b0;
        peek(8'h10, 8'h5A, "drop_wr");
        wr_t(8'hF5, 8'hAA);
        chk("err_unmap", {7'b0, err}, 8'h01);
        peek(8'hF5, 8'h00, "rd_unmap");
        peek(8'hF0, 8'h00, "rd_unmap_lo");
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_t(8'h05, 8'h99);
`ifdef DMEM_WPROT_EN
        chk("wp_err", {7'b0, err}, 8'h01);
`else
        peek(8'h05, 8'h99, "wp_off_rd");
        chk("wp_off_err", {7'b0, err}, 8'h00);
`endif
        wr_t(8'hFD, 8'h55);
        wr_t(8'hFE, 8'h55);
        peek(8'hFD, WP ? 8'h02 : 8'h00, "stat_ro");
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
